// File: rtl/binary_serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: the master issues start and operands,
// the slave returns busy/done status and the registered result.
interface binary_serial_subtractor_if #(
  parameter int N = 16
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/binary_serial_subtractor.sv
// Bit-serial diff = a - b - bin, LSB first through one full-subtractor cell; N+1 cycles to done.
// start is sampled only in IDLE and never queued; busy/done are decoded from registered state.
module binary_serial_subtractor #(
  parameter int N = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  binary_serial_subtractor_if.slave    bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  shift_a;
  logic [N-1:0]  shift_b;
  logic [N-1:0]  diff_q;
  logic          borrow;
  logic          bout_q;
  logic [CW-1:0] cnt;

  logic x;
  logic y;
  logic d;
  logic br_next;
  logic last_bit;

  // Single full-subtractor cell shared by every bit position
  assign x        = shift_a[0];
  assign y        = shift_b[0];
  assign d        = x ^ y ^ borrow;
  assign br_next  = (~x & y) | (~(x ^ y) & borrow);
  assign last_bit = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_a <= '0;
      shift_b <= '0;
      diff_q  <= '0;
      borrow  <= 1'b0;
      bout_q  <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          // bout keeps the previous result until the new final borrow lands
          if (bus.start) begin
            shift_a <= bus.a;
            shift_b <= bus.b;
            borrow  <= bus.bin;
            cnt     <= '0;
            diff_q  <= '0;
          end
        end
        SHIFT: begin
          shift_a <= {1'b0, shift_a[N-1:1]};
          shift_b <= {1'b0, shift_b[N-1:1]};
          diff_q  <= {d, diff_q[N-1:1]};
          borrow  <= br_next;
          if (last_bit) begin
            bout_q <= br_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_binary_serial_subtractor.sv
// Directed and random checks of the bit-serial subtractor at N=16 and N=5 against an arithmetic model.
module tb_binary_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary_serial_subtractor_if #(.N(16)) bus16 ();
  binary_serial_subtractor_if #(.N(5))  bus5 ();

  binary_serial_subtractor #(.N(16)) u16 (.clk(clk), .rst(rst), .bus(bus16));
  binary_serial_subtractor #(.N(5))  u5  (.clk(clk), .rst(rst), .bus(bus5));

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    int          e0;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic int width(input int inst);
    return (inst == 0) ? 16 : 5;
  endfunction

  // Reference: {bout,diff} = ({1'b0,a} - b - bin) mod 2^(n+1)
  function automatic logic [16:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    logic [31:0] m;
    logic [31:0] r;
    m = (32'd1 << n) - 32'd1;
    r = ({16'd0, a} & m) - ({16'd0, b} & m) - {31'd0, bin};
    return {r[n], r[15:0] & m[15:0]};
  endfunction

  task automatic drive(input int inst, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    if (inst == 0) begin
      bus16.start = s; bus16.a = a; bus16.b = b; bus16.bin = bin;
    end else begin
      bus5.start = s; bus5.a = a[4:0]; bus5.b = b[4:0]; bus5.bin = bin;
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? bus16.busy : bus5.busy;
  endfunction

  function automatic logic get_done(input int inst);
    return (inst == 0) ? bus16.done : bus5.done;
  endfunction

  function automatic logic [15:0] get_diff(input int inst);
    return (inst == 0) ? bus16.diff : {11'd0, bus5.diff};
  endfunction

  function automatic logic get_bout(input int inst);
    return (inst == 0) ? bus16.bout : bus5.bout;
  endfunction

  // Entered and left just after a falling edge with the DUT idle.
  // hold=1 keeps start high with 0xFFFF - 0x0000 presented for the whole operation.
  task automatic do_op(input int inst, input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input bit hold);
    int          n;
    int          nbusy;
    bit          got;
    logic [16:0] r;
    exp_t        e;
    n = width(inst);
    check("idle_before_start", {31'd0, get_busy(inst)}, 32'd0);
    drive(inst, 1'b1, a, b, bin);
    r = model(n, a, b, bin);
    sb.push_back('{diff: r[15:0], bout: r[16], e0: cyc + 1});
    got   = 0;
    nbusy = 0;
    for (int k = 0; k < n + 4 && !got; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) drive(inst, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
        else      drive(inst, 1'b0, a, b, bin);
      end
      if (get_busy(inst)) nbusy++;
      if (get_busy(inst) && get_done(inst)) check("busy_done_overlap", 32'd1, 32'd0);
      if (get_done(inst)) begin
        got = 1;
        e = sb.pop_front();
        check("diff", {16'd0, get_diff(inst)}, {16'd0, e.diff});
        check("bout", {31'd0, get_bout(inst)}, {31'd0, e.bout});
        check("done_latency", cyc - e.e0, n);
        check("busy_cycles", nbusy, n);
      end
    end
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(negedge clk);
    check("idle_after_done", {30'd0, get_busy(inst), get_done(inst)}, 32'd0);
    if (got) check("diff_hold", {16'd0, get_diff(inst)}, {16'd0, e.diff});
  endtask

  initial begin
    int  e0;
    bit  spurious;

    rst = 1'b1;
    drive(0, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(1, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, bus16.busy}, 32'd0);
    check("rst_done", {31'd0, bus16.done}, 32'd0);
    check("rst_diff", {16'd0, bus16.diff}, 32'd0);
    check("rst_bout", {31'd0, bus16.bout}, 32'd0);
    check("rst_n5", {25'd0, bus5.busy, bus5.done, bus5.diff}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(0, 16'h0005, 16'h0003, 1'b0, 0);
    do_op(0, 16'h0003, 16'h0005, 1'b0, 0);
    do_op(0, 16'h0000, 16'h0001, 1'b0, 0);
    do_op(0, 16'h8000, 16'h8000, 1'b1, 0);
    do_op(0, 16'h1234, 16'h1234, 1'b0, 0);

    // Held start: ignored while busy/done, accepted again at the first IDLE edge
    do_op(0, 16'h0010, 16'h0001, 1'b0, 1);
    do_op(0, 16'hFFFF, 16'h0000, 1'b0, 0);

    // Reset while bit 7 of 0x00FF - 0x0001 is due
    drive(0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
    e0 = cyc + 1;
    @(negedge clk);
    drive(0, 1'b0, 16'h00FF, 16'h0001, 1'b0);
    repeat (7) @(negedge clk);
    check("abort_edge", cyc - e0, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus16.busy}, 32'd0);
    check("abort_done", {31'd0, bus16.done}, 32'd0);
    check("abort_diff", {16'd0, bus16.diff}, 32'd0);
    check("abort_bout", {31'd0, bus16.bout}, 32'd0);
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus16.done || bus16.busy) spurious = 1;
    end
    check("abort_no_done", {31'd0, spurious}, 32'd0);
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 1000; i++)
      do_op(0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    do_op(1, 16'h0000, 16'h001F, 1'b1, 0);
    do_op(1, 16'h001F, 16'h0000, 1'b0, 0);
    for (int i = 0; i < 1000; i++)
      do_op(1, 16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
